// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of a single SRAM controller port.
// One transaction in flight; a watchdog aborts transactions the controller never acknowledges.
module sram_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_wrEnIn,
    input  logic          m0_rdEnIn,
    input  logic [AW-1:0] m0_addressIn,
    input  logic [DW-1:0] m0_writeDataIn,
    output logic [DW-1:0] m0_readDataOut,
    output logic          m0_readyOut,

    input  logic          m1_wrEnIn,
    input  logic          m1_rdEnIn,
    input  logic [AW-1:0] m1_addressIn,
    input  logic [DW-1:0] m1_writeDataIn,
    output logic [DW-1:0] m1_readDataOut,
    output logic          m1_readyOut,

    output logic          ctl_wrEnOut,
    output logic          ctl_rdEnOut,
    output logic [AW-1:0] ctl_addressOut,
    output logic [DW-1:0] ctl_writeDataOut,
    input  logic [DW-1:0] ctl_readDataIn,
    input  logic          ctl_readyIn,

    output logic [1:0]    grantOut,
    output logic          errorOut,
    input  logic          clrErrIn,
    output logic [CW-1:0] m0_countOut,
    output logic [CW-1:0] m1_countOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e        state_q;
    logic [1:0]    grant_q;
    logic          last_q;      // 1: m1 was served last, so m0 wins the next tie
    logic [15:0]   wdog_q;
    logic          err_q;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;

    logic req0, req1;
    logic busy0, busy1, busy, own_req;
    logic done, flush, expire;
    logic abort0, abort1;

    always_comb begin
        req0    = m0_wrEnIn | m0_rdEnIn;
        req1    = m1_wrEnIn | m1_rdEnIn;
        busy0   = (state_q == BUSY0);
        busy1   = (state_q == BUSY1);
        busy    = busy0 | busy1;
        own_req = busy1 ? req1 : req0;
        done    = busy & own_req & ctl_readyIn;
        flush   = busy & ~own_req;
        expire  = busy & own_req & ~ctl_readyIn & (wdog_q == 16'(TIMEOUT - 1));
        abort0  = (state_q == ABORT) & grant_q[0];
        abort1  = (state_q == ABORT) & grant_q[1];
    end

    // Controller side follows the owner combinationally; write masks read.
    always_comb begin
        ctl_wrEnOut      = 1'b0;
        ctl_rdEnOut      = 1'b0;
        ctl_addressOut   = '0;
        ctl_writeDataOut = '0;
        case (state_q)
            BUSY0: begin
                ctl_wrEnOut      = m0_wrEnIn;
                ctl_rdEnOut      = m0_rdEnIn & ~m0_wrEnIn;
                ctl_addressOut   = m0_addressIn;
                ctl_writeDataOut = m0_writeDataIn;
            end
            BUSY1: begin
                ctl_wrEnOut      = m1_wrEnIn;
                ctl_rdEnOut      = m1_rdEnIn & ~m1_wrEnIn;
                ctl_addressOut   = m1_addressIn;
                ctl_writeDataOut = m1_writeDataIn;
            end
            default: ;
        endcase
    end

    always_comb begin
        m0_readyOut    = ~req0 | (busy0 & done) | abort0;
        m1_readyOut    = ~req1 | (busy1 & done) | abort1;
        m0_readDataOut = abort0 ? '0 : ctl_readDataIn;
        m1_readDataOut = abort1 ? '0 : ctl_readDataIn;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            if (expire) begin
                err_q <= 1'b1;
            end else if (clrErrIn) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= BUSY0;
                        grant_q <= 2'b01;
                    end else if (req1) begin
                        state_q <= BUSY1;
                        grant_q <= 2'b10;
                    end
                end
                BUSY0, BUSY1: begin
                    if (flush) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end else if (done) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= busy1;
                        if (busy1) begin
                            cnt1_q <= cnt1_q + CW'(1);
                        end else begin
                            cnt0_q <= cnt0_q + CW'(1);
                        end
                    end else if (expire) begin
                        state_q <= ABORT;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    last_q  <= grant_q[1];
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grantOut    = grant_q;
    assign errorOut    = err_q;
    assign m0_countOut = cnt0_q;
    assign m1_countOut = cnt1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table plus hand sequences
// for latency, timeout/error flag, mid-transaction reset and flush.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_wrEnIn, m0_rdEnIn;
    logic [31:0] m0_addressIn, m0_writeDataIn, m0_readDataOut;
    logic        m0_readyOut;
    logic        m1_wrEnIn, m1_rdEnIn;
    logic [31:0] m1_addressIn, m1_writeDataIn, m1_readDataOut;
    logic        m1_readyOut;
    logic        ctl_wrEnOut, ctl_rdEnOut;
    logic [31:0] ctl_addressOut, ctl_writeDataOut, ctl_readDataIn;
    logic        ctl_readyIn;
    logic [1:0]  grantOut;
    logic        errorOut, clrErrIn;
    logic [15:0] m0_countOut, m1_countOut;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(32), .DW(32), .CW(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_wrEnIn(m0_wrEnIn), .m0_rdEnIn(m0_rdEnIn), .m0_addressIn(m0_addressIn),
        .m0_writeDataIn(m0_writeDataIn), .m0_readDataOut(m0_readDataOut), .m0_readyOut(m0_readyOut),
        .m1_wrEnIn(m1_wrEnIn), .m1_rdEnIn(m1_rdEnIn), .m1_addressIn(m1_addressIn),
        .m1_writeDataIn(m1_writeDataIn), .m1_readDataOut(m1_readDataOut), .m1_readyOut(m1_readyOut),
        .ctl_wrEnOut(ctl_wrEnOut), .ctl_rdEnOut(ctl_rdEnOut), .ctl_addressOut(ctl_addressOut),
        .ctl_writeDataOut(ctl_writeDataOut), .ctl_readDataIn(ctl_readDataIn), .ctl_readyIn(ctl_readyIn),
        .grantOut(grantOut), .errorOut(errorOut), .clrErrIn(clrErrIn),
        .m0_countOut(m0_countOut), .m1_countOut(m1_countOut)
    );

    typedef struct {
        logic [1:0]  m0_we;   // {wrEn, rdEn}
        logic [31:0] m0_a, m0_d;
        logic [1:0]  m1_we;
        logic [31:0] m1_a, m1_d;
        logic        rdy;
        logic [31:0] rdat;
        logic [1:0]  e_gnt;
        logic        e_wr, e_rd;
        logic [31:0] e_addr, e_wdat;
        logic        e_r0, e_r1;
        logic [15:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] m0we, input logic [31:0] m0a, input logic [31:0] m0d,
                       input logic [1:0] m1we, input logic [31:0] m1a, input logic [31:0] m1d,
                       input logic rdy, input logic [31:0] rdat,
                       input logic [1:0] gnt, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input logic r0, input logic r1, input logic [15:0] c0, input logic [15:0] c1);
        vec_t v;
        v.m0_we = m0we; v.m0_a = m0a; v.m0_d = m0d;
        v.m1_we = m1we; v.m1_a = m1a; v.m1_d = m1d;
        v.rdy = rdy; v.rdat = rdat;
        v.e_gnt = gnt; v.e_wr = wr; v.e_rd = rd; v.e_addr = addr; v.e_wdat = wdat;
        v.e_r0 = r0; v.e_r1 = r1; v.e_c0 = c0; v.e_c1 = c1;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_wrEnIn = 0; m0_rdEnIn = 0; m0_addressIn = '0; m0_writeDataIn = '0;
        m1_wrEnIn = 0; m1_rdEnIn = 0; m1_addressIn = '0; m1_writeDataIn = '0;
        ctl_readDataIn = '0; ctl_readyIn = 0; clrErrIn = 0;
    endtask

    // Leaves the bench in the first post-reset cycle (state IDLE), #1 after the edge.
    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        int busy, first, found;
        logic [31:0] cap;
        logic gnt_ok, addr_ok, err_abort, err_busy_ok, rden_abort;

        rst = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // Table: idle, tie alternation, wr-over-rd, minimum latency, flush.
        add(2'b00,0,0,       2'b00,0,0,       0,0,            2'b00,0,0,0,0,         1,1, 0,0);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b00,0,0,0,0,         0,0, 0,0);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b01,1,0,32'h8,32'h11, 1,0, 0,0);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b00,0,0,0,0,         0,0, 1,0);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b10,1,0,32'hC,32'h22, 0,1, 1,0);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b00,0,0,0,0,         0,0, 1,1);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b01,1,0,32'h8,32'h11, 1,0, 1,1);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b00,0,0,0,0,         0,0, 2,1);
        add(2'b10,32'h8,32'h11, 2'b10,32'hC,32'h22, 1,0,      2'b10,1,0,32'hC,32'h22, 0,1, 2,1);
        add(2'b00,32'h8,32'h11, 2'b00,32'hC,32'h22, 0,0,      2'b00,0,0,0,0,         1,1, 2,2);
        add(2'b00,0,0,       2'b11,32'h10,32'h55, 0,0,        2'b00,0,0,0,0,         1,0, 2,2);
        add(2'b00,0,0,       2'b11,32'h10,32'h55, 0,0,        2'b10,1,0,32'h10,32'h55, 1,0, 2,2);
        add(2'b00,0,0,       2'b11,32'h10,32'h55, 1,32'h12345678, 2'b10,1,0,32'h10,32'h55, 1,1, 2,2);
        add(2'b00,0,0,       2'b00,0,0,       0,0,            2'b00,0,0,0,0,         1,1, 2,3);
        add(2'b01,32'h20,0,  2'b00,0,0,       1,32'hA5A5A5A5, 2'b00,0,0,0,0,         0,1, 2,3);
        add(2'b01,32'h20,0,  2'b00,0,0,       1,32'hA5A5A5A5, 2'b01,0,1,32'h20,0,    1,1, 2,3);
        add(2'b00,0,0,       2'b00,0,0,       0,0,            2'b00,0,0,0,0,         1,1, 3,3);
        add(2'b10,32'h30,32'h77, 2'b00,0,0,   0,0,            2'b00,0,0,0,0,         0,1, 3,3);
        add(2'b10,32'h30,32'h77, 2'b00,0,0,   0,0,            2'b01,1,0,32'h30,32'h77, 0,1, 3,3);
        add(2'b00,32'h30,32'h77, 2'b00,0,0,   0,0,            2'b01,0,0,32'h30,32'h77, 1,1, 3,3);
        add(2'b00,0,0,       2'b00,0,0,       0,0,            2'b00,0,0,0,0,         1,1, 3,3);
        add(2'b00,0,0,       2'b00,0,0,       0,0,            2'b00,0,0,0,0,         1,1, 3,3);

        foreach (tbl[i]) begin
            {m0_wrEnIn, m0_rdEnIn} = tbl[i].m0_we;
            m0_addressIn = tbl[i].m0_a; m0_writeDataIn = tbl[i].m0_d;
            {m1_wrEnIn, m1_rdEnIn} = tbl[i].m1_we;
            m1_addressIn = tbl[i].m1_a; m1_writeDataIn = tbl[i].m1_d;
            ctl_readyIn = tbl[i].rdy; ctl_readDataIn = tbl[i].rdat;
            @(negedge clk);
            chk($sformatf("v%0d grant", i),  32'(grantOut),     32'(tbl[i].e_gnt));
            chk($sformatf("v%0d ctl_wr", i), 32'(ctl_wrEnOut),  32'(tbl[i].e_wr));
            chk($sformatf("v%0d ctl_rd", i), 32'(ctl_rdEnOut),  32'(tbl[i].e_rd));
            chk($sformatf("v%0d addr", i),   ctl_addressOut,    tbl[i].e_addr);
            chk($sformatf("v%0d wdata", i),  ctl_writeDataOut,  tbl[i].e_wdat);
            chk($sformatf("v%0d m0_rdy", i), 32'(m0_readyOut),  32'(tbl[i].e_r0));
            chk($sformatf("v%0d m1_rdy", i), 32'(m1_readyOut),  32'(tbl[i].e_r1));
            chk($sformatf("v%0d m0_rdat", i), m0_readDataOut,   tbl[i].rdat);
            chk($sformatf("v%0d m1_rdat", i), m1_readDataOut,   tbl[i].rdat);
            chk($sformatf("v%0d err", i),    32'(errorOut),     32'd0);
            chk($sformatf("v%0d cnt0", i),   32'(m0_countOut),  32'(tbl[i].e_c0));
            chk($sformatf("v%0d cnt1", i),   32'(m1_countOut),  32'(tbl[i].e_c1));
            @(posedge clk); #1;
        end

        // Single read: ready held low for 5 BUSY cycles, completion in the 7th cycle of the request.
        reset_dut();
        m0_rdEnIn = 1; m0_addressIn = 32'h0000_0400; ctl_readDataIn = 32'hDEADBEEF;
        busy = 0; first = 0; gnt_ok = 1; addr_ok = 1; cap = '0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (grantOut == 2'b01) busy++;
            ctl_readyIn = (busy == 6);
            @(negedge clk);
            if (n >= 2 && grantOut != 2'b01) gnt_ok = 0;
            if (n >= 2 && (ctl_addressOut != 32'h400 || ctl_rdEnOut != 1'b1)) addr_ok = 0;
            if (m0_readyOut) begin first = n; cap = m0_readDataOut; end
        end
        chk("rd latency", 32'(first), 32'd7);
        chk("rd data", cap, 32'hDEADBEEF);
        chk("rd grant busy", 32'(gnt_ok), 32'd1);
        chk("rd ctl addr", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        m0_rdEnIn = 0; ctl_readyIn = 0;
        @(negedge clk);
        chk("rd count", 32'(m0_countOut), 32'd1);
        chk("rd grant idle", 32'(grantOut), 32'd0);

        // Timeout: controller never ready; 8 BUSY cycles then one ABORT cycle.
        reset_dut();
        m1_rdEnIn = 1; m1_addressIn = 32'h44; ctl_readDataIn = 32'hCAFEF00D;
        busy = 0; found = 0; cap = '1; err_abort = 0; rden_abort = 1;
        for (int n = 0; n < 30 && found == 0; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (m1_readyOut) begin
                found = 1; cap = m1_readDataOut; err_abort = errorOut; rden_abort = ctl_rdEnOut;
            end else if (ctl_rdEnOut) busy++;
        end
        chk("to ready seen", 32'(found), 32'd1);
        chk("to busy cycles", 32'(busy), 32'd8);
        chk("to abort data", cap, 32'd0);
        chk("to err set", 32'(err_abort), 32'd1);
        chk("to abort rden", 32'(rden_abort), 32'd0);
        @(posedge clk); #1;
        m1_rdEnIn = 0;
        @(negedge clk);
        chk("to err sticky", 32'(errorOut), 32'd1);
        chk("to cnt1", 32'(m1_countOut), 32'd0);
        @(posedge clk); #1;
        clrErrIn = 1;
        @(posedge clk); #1;
        clrErrIn = 0;
        @(negedge clk);
        chk("to err clr", 32'(errorOut), 32'd0);

        // Clear held through a second timeout: the set must win on the abort edge.
        @(posedge clk); #1;
        clrErrIn = 1; m1_rdEnIn = 1;
        found = 0; err_abort = 0; err_busy_ok = 1;
        for (int n = 0; n < 30 && found == 0; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (m1_readyOut) begin found = 1; err_abort = errorOut; end
            else if (errorOut) err_busy_ok = 0;
        end
        chk("to2 ready seen", 32'(found), 32'd1);
        chk("to2 err busy", 32'(err_busy_ok), 32'd1);
        chk("to2 set wins", 32'(err_abort), 32'd1);
        @(posedge clk); #1;
        m1_rdEnIn = 0;
        @(negedge clk);
        chk("to2 err cleared", 32'(errorOut), 32'd0);
        clrErrIn = 0;

        // Reset mid-BUSY0 with a nonzero m1 count, then the held m0 request is regranted.
        reset_dut();
        m1_wrEnIn = 1; m1_addressIn = 32'h60; ctl_readyIn = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst m1 done", 32'(m1_readyOut), 32'd1);
        @(posedge clk); #1;
        m1_wrEnIn = 0; ctl_readyIn = 0;
        m0_wrEnIn = 1; m0_addressIn = 32'h50; m0_writeDataIn = 32'h99;
        @(negedge clk);
        chk("rst cnt1 pre", 32'(m1_countOut), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst busy wr", 32'(ctl_wrEnOut), 32'd1);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rst ctl_wr", 32'(ctl_wrEnOut), 32'd0);
        chk("rst grant", 32'(grantOut), 32'd0);
        chk("rst cnt0", 32'(m0_countOut), 32'd0);
        chk("rst cnt1", 32'(m1_countOut), 32'd0);
        chk("rst m0_rdy", 32'(m0_readyOut), 32'd0);
        @(posedge clk); #1;
        ctl_readyIn = 1;
        @(negedge clk);
        chk("rst regrant", 32'(grantOut), 32'd1);
        chk("rst m0 done", 32'(m0_readyOut), 32'd1);
        @(posedge clk); #1;
        m0_wrEnIn = 0; ctl_readyIn = 0;
        @(negedge clk);
        chk("rst cnt0 post", 32'(m0_countOut), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
